button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Input-side front end for the stopwatch/clock UI; the display path is the output side.
- Turns N raw, bouncy, asynchronous push-button/switch levels into clean synchronous signals per channel:
  - a debounced level,
  - one-cycle press and release pulses,
  - a press-toggled level.
- Outputs drive the add-sec/min/hr pulse inputs and the start/stop and stopwatch/clock select inputs of the timekeeping logic.

Parameters:
- N_BTN, 5: number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz). Must be >= 1.
- REPEAT_DELAY, 50_000_000: hold time in cycles before the first auto-repeat pulse. Used only with AUTOREPEAT_EN.
- REPEAT_PERIOD, 25_000_000: cycles between later auto-repeat pulses. Used only with AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- i_btn  input  N_BTN  raw asynchronous button levels; 1 = pressed.
- o_level  output  N_BTN  debounced level.
- o_press  output  N_BTN  one-cycle pulse per accepted press (plus repeats, see feature).
- o_release  output  N_BTN  one-cycle pulse per accepted release.
- o_toggle  output  N_BTN  flips on each accepted press.

Behaviour:
- Reset and interface:
  - One clock; reset is asynchronous and active-high.
  - On rst: all synchronizer flops, FSMs and counters are cleared.
  - Reset values: o_level=0, o_press=0, o_release=0, o_toggle=0.
  - Reset mid-debounce abandons the pending change with no pulse.
- Per channel, fully independent; simultaneous activity on several channels is handled with no interaction.
- Synchronizer: 2-FF on i_btn[k] giving s[k].
- FSM states: LO, DEB_HI, HI, DEB_LO. One counter per channel, width $clog2(DEBOUNCE_CYCLES+1).
- LO:
  - If s=1: go to DEB_HI, cnt=1.
- DEB_HI:
  - If s=0: back to LO, cnt=0. Bounce is rejected with no pulse.
  - Else if cnt==DEBOUNCE_CYCLES: go to HI, set o_level=1, pulse o_press for 1 cycle, invert o_toggle.
  - Else cnt++.
- HI / DEB_LO: mirror of LO / DEB_HI. Accepting the low level clears o_level and pulses o_release for 1 cycle.
- Latency:
  - Raw edge stable from the first sampling clock edge E.
  - o_level, o_press and o_toggle update at edge E+2+DEBOUNCE_CYCLES (2 synchronizer stages, then DEBOUNCE_CYCLES stable FSM samples).
  - Release path has the same latency.
- Pulse and level rules:
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
  - o_press and o_release are never high in the same cycle on the same channel.
  - o_press is never high for 2 consecutive cycles.
- Counters saturate; there is no wrap-around.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - While in HI, a hold counter runs from the entry to HI.
  - After REPEAT_DELAY cycles, o_press pulses once more; then it pulses every REPEAT_PERIOD cycles until the FSM leaves HI.
  - Repeat pulses do not flip o_toggle.
  - The hold counter clears on leaving HI and on rst.
  - Gives fast time-setting when add buttons are held.
- Undefined:
  - The hold counter logic is absent.
  - Exactly one o_press per accepted press.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
(All with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, N_BTN=5.)
1. Clean press: i_btn[0] 0->1 sampled at edge 0, held -> o_press[0]=1 only in the cycle after edge 6; o_level[0]=1 from edge 6; o_toggle[0]=1. Release -> o_release[0] pulse at the same 6-edge latency, o_level[0]=0.
2. Bounce: i_btn[1] toggles 1,0,1,0 each 2 cycles, then stays 1 -> no pulse during bouncing; exactly one o_press[1], 6 edges after the final rising sample.
3. Independence: i_btn[2] and i_btn[3] pressed on the same edge -> both o_press pulses in the same cycle; other channels stay 0.
4. Reset mid-operation: press i_btn[4], assert rst at edge 3 (inside DEB_HI) -> all outputs 0 immediately (asynchronous); no pulse after rst release until a fresh 6-edge stable press.
5. Toggle: 3 accepted presses on ch0 -> o_toggle[0] goes 1,0,1.
6. AUTOREPEAT_EN held: hold ch0 for 40 cycles -> o_press[0] pulses at acceptance, +10, +15, +20, +25, +30 cycles; o_toggle[0] flips once. Without the macro -> a single pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchronizer + debounce FSM producing level, press/release pulses and a toggle.
// Define AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LO     = 2'd0,
        DEB_HI = 2'd1,
        HI     = 2'd2,
        DEB_LO = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cfg_check
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

`ifdef AUTOREPEAT_EN
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_check
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_note
        $warning("button_conditioner: repeat parameters are unused in this build");
    end
`endif

    for (genvar k = 0; k < N_BTN; k++) begin : g_ch
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             toggle_q, toggle_d;
`ifdef AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             rpt_armed_q, rpt_armed_d;
`endif

        always_comb begin
            sync1_d   = i_btn[k];
            sync2_d   = sync1_q;
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            toggle_d  = toggle_q;

            // The counter only advances while the new level keeps holding, so it never exceeds CNT_MAX.
            unique case (state_q)
                LO: begin
                    if (sync2_q) begin
                        state_d = DEB_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                DEB_HI: begin
                    if (!sync2_q) begin
                        state_d = LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d  = HI;
                        cnt_d    = '0;
                        level_d  = 1'b1;
                        press_d  = 1'b1;
                        toggle_d = ~toggle_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HI: begin
                    if (!sync2_q) begin
                        state_d = DEB_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                DEB_LO: begin
                    if (sync2_q) begin
                        state_d = HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = LO;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = LO;
                    cnt_d   = '0;
                end
            endcase

`ifdef AUTOREPEAT_EN
            rpt_d       = '0;
            rpt_armed_d = 1'b0;
            // Hold time restarts whenever HI is (re)entered; first gap is the delay, later gaps the period.
            if (state_q == HI && state_d == HI) begin
                rpt_d       = rpt_q + RPT_ONE;
                rpt_armed_d = rpt_armed_q;
                if (!rpt_armed_q && rpt_d == RPT_DELAY) begin
                    press_d     = 1'b1;
                    rpt_d       = '0;
                    rpt_armed_d = 1'b1;
                end else if (rpt_armed_q && rpt_d == RPT_PERIOD) begin
                    press_d = 1'b1;
                    rpt_d   = '0;
                end
            end
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q     <= 1'b0;
                sync2_q     <= 1'b0;
                state_q     <= LO;
                cnt_q       <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                toggle_q    <= 1'b0;
`ifdef AUTOREPEAT_EN
                rpt_q       <= '0;
                rpt_armed_q <= 1'b0;
`endif
            end else begin
                sync1_q     <= sync1_d;
                sync2_q     <= sync2_d;
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                toggle_q    <= toggle_d;
`ifdef AUTOREPEAT_EN
                rpt_q       <= rpt_d;
                rpt_armed_q <= rpt_armed_d;
`endif
            end
        end

        assign o_level[k]   = level_q;
        assign o_press[k]   = press_q;
        assign o_release[k] = release_q;
        assign o_toggle[k]  = toggle_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized bouncing,
// compared every cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] i_btn = '0;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;
    logic [N-1:0] o_toggle;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a level is accepted once the 2-cycle-delayed raw input has
    // disagreed with the current level for D+1 consecutive clock edges.
    logic [N-1:0] m_level, m_press, m_release, m_toggle;
    logic [N-1:0] prev_press;
    logic [N-1:0] hist[$];
    int           run[N];
    int           hold[N];
    bit           in_hi_prev[N];

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_toggle (o_toggle)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_level    = '0;
        m_press    = '0;
        m_release  = '0;
        m_toggle   = '0;
        prev_press = '0;
        hist.delete();
        for (int k = 0; k < N; k++) begin
            run[k]        = 0;
            hold[k]       = 0;
            in_hi_prev[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        bit           in_hi;
        hist.push_front(i_btn);
        if (hist.size() > 3) void'(hist.pop_back());
        s = (hist.size() == 3) ? hist[2] : '0;
        m_press   = '0;
        m_release = '0;
        for (int k = 0; k < N; k++) begin
            if (s[k] != m_level[k]) run[k]++;
            else run[k] = 0;
            if (run[k] == D + 1) begin
                m_level[k] = ~m_level[k];
                run[k]     = 0;
                if (m_level[k]) begin
                    m_press[k]  = 1'b1;
                    m_toggle[k] = ~m_toggle[k];
                end else begin
                    m_release[k] = 1'b1;
                end
            end
            in_hi = m_level[k] && (run[k] == 0);
            if (in_hi && in_hi_prev[k]) hold[k]++;
            else hold[k] = 0;
`ifdef AUTOREPEAT_EN
            if (in_hi && in_hi_prev[k] && hold[k] >= RD && ((hold[k] - RD) % RP) == 0)
                m_press[k] = 1'b1;
`endif
            in_hi_prev[k] = in_hi;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else model_step();
        #1;
        check_val("level",   32'(o_level),   32'(m_level));
        check_val("press",   32'(o_press),   32'(m_press));
        check_val("release", 32'(o_release), 32'(m_release));
        check_val("toggle",  32'(o_toggle),  32'(m_toggle));
        check_val("press_and_release_same_cycle", 32'(o_press & o_release), 32'(0));
        check_val("press_two_cycles", 32'(o_press & prev_press), 32'(0));
        prev_press = o_press;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_clear();
        #1;
        check_val({tag, "_level"},   32'(o_level),   32'(0));
        check_val({tag, "_press"},   32'(o_press),   32'(0));
        check_val({tag, "_release"}, 32'(o_release), 32'(0));
        check_val({tag, "_toggle"},  32'(o_toggle),  32'(0));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int presses;
        int hold_left[N];

        model_clear();
        rst   = 1'b1;
        i_btn = '0;
        repeat (3) tick();
        check_val("reset_level",  32'(o_level),  32'(0));
        check_val("reset_toggle", 32'(o_toggle), 32'(0));
        rst = 1'b0;
        repeat (2) tick();

        // Clean press and release on channel 0
        i_btn[0] = 1'b1;
        repeat (6) tick();
        check_val("t1_press_early", 32'(o_press[0]), 32'(0));
        tick();
        check_val("t1_press",  32'(o_press[0]),  32'(1));
        check_val("t1_level",  32'(o_level[0]),  32'(1));
        check_val("t1_toggle", 32'(o_toggle[0]), 32'(1));
        tick();
        check_val("t1_press_one_cycle", 32'(o_press[0]), 32'(0));
        repeat (4) tick();
        i_btn[0] = 1'b0;
        repeat (6) tick();
        check_val("t1_release_early", 32'(o_release[0]), 32'(0));
        tick();
        check_val("t1_release",   32'(o_release[0]), 32'(1));
        check_val("t1_level_low", 32'(o_level[0]),   32'(0));
        repeat (4) tick();

        // Bounce on channel 1, then a stable press
        presses = 0;
        for (int r = 0; r < 2; r++) begin
            i_btn[1] = 1'b1;
            repeat (2) begin tick(); presses += int'(o_press[1]); end
            i_btn[1] = 1'b0;
            repeat (2) begin tick(); presses += int'(o_press[1]); end
        end
        i_btn[1] = 1'b1;
        repeat (6) begin tick(); presses += int'(o_press[1]); end
        check_val("t2_no_press_while_bouncing", 32'(presses), 32'(0));
        tick();
        check_val("t2_press", 32'(o_press[1]), 32'(1));
        presses = 1;
        repeat (6) begin tick(); presses += int'(o_press[1]); end
        check_val("t2_single_press", 32'(presses), 32'(1));
        i_btn[1] = 1'b0;
        repeat (10) tick();

        // Two channels pressed on the same edge
        i_btn[3:2] = 2'b11;
        repeat (6) tick();
        tick();
        check_val("t3_press_both", 32'(o_press), 32'(5'b01100));
        check_val("t3_level_both", 32'(o_level), 32'(5'b01100));
        i_btn[3:2] = 2'b00;
        repeat (10) tick();

        // Reset in the middle of a debounce on channel 4
        i_btn[4] = 1'b1;
        repeat (4) tick();
        async_reset("t4_async");
        tick();
        repeat (5) tick();
        check_val("t4_no_press_early", 32'(o_press[4]), 32'(0));
        tick();
        check_val("t4_fresh_press", 32'(o_press[4]), 32'(1));
        i_btn[4] = 1'b0;
        repeat (10) tick();

        // Toggle across three accepted presses on channel 0
        for (int i = 0; i < 3; i++) begin
            i_btn[0] = 1'b1;
            repeat (8) tick();
            check_val($sformatf("t5_toggle_%0d", i), 32'(o_toggle[0]), (i % 2 == 0) ? 32'(1) : 32'(0));
            i_btn[0] = 1'b0;
            repeat (8) tick();
        end

        // Long hold on channel 0
        presses  = 0;
        i_btn[0] = 1'b1;
        repeat (40) begin tick(); presses += int'(o_press[0]); end
`ifdef AUTOREPEAT_EN
        check_val("t6_hold_presses", 32'(presses), 32'(6));
`else
        check_val("t6_hold_presses", 32'(presses), 32'(1));
`endif
        check_val("t6_toggle_once", 32'(o_toggle[0]), 32'(0));
        i_btn[0] = 1'b0;
        repeat (10) tick();

        // Randomized bouncing with occasional asynchronous resets
        for (int k = 0; k < N; k++) hold_left[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (hold_left[k] == 0) begin
                    i_btn[k]     = 1'($urandom_range(0, 1));
                    hold_left[k] = int'($urandom_range(1, 25));
                end
                hold_left[k]--;
            end
            if ($urandom_range(0, 299) == 0) async_reset("rand_async");
            else tick();
        end

        i_btn = '0;
        repeat (12) tick();
        check_val("final_level_idle", 32'(o_level), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
